dma_burst_ctrl: RTL and testbench
=================================

Name: dma_burst_ctrl

Overview:
- Downstream consumer of the ADC stream FIFO, in the trn_clk domain.
- Drains the FIFO in fixed-size bursts whenever dma_ready is high and presents each burst to the PCIe TLP transmit engine as one memory-write request (address, length, data beats).
- Walks a host ring buffer split into two halves and raises a per-half interrupt pulse.
- Flags a sticky overrun when the host has not acknowledged the previous half in time.

Parameters:
- BURST_WORDS, 32: DWORDs per MWr TLP (128 B payload). Must be a power of two, ≤ 1023.
- ADDR_WIDTH, 32: host address width.

Ports:
- trn_clk  in  1  PCIe user clock; all logic on its rising edge.
- pio_reset_n  in  1  asynchronous active-low reset.
- dma_enable  in  1  level; a rising edge while IDLE (re)starts at buf_base_addr.
- buf_base_addr  in  ADDR_WIDTH  host buffer base; bits[1:0] ignored (forced 0). Sampled on the dma_enable rising edge.
- buf_half_bursts  in  16  bursts per buffer half; 0 is treated as 1. Sampled on the dma_enable rising edge.
- dma_ready  in  1  FIFO holds ≥ BURST_WORDS words. The FIFO prog_empty threshold is set accordingly; this block does not check for underflow.
- PCIe_dma_rd_en  out  1  FIFO read strobe; data is valid one cycle later.
- fifo_data  in  32  FIFO dout.
- mwr_req  out  1  TLP request.
- mwr_addr  out  ADDR_WIDTH  TLP address.
- mwr_len  out  10  TLP length in DW (= BURST_WORDS).
- mwr_ack  in  1  engine accepted the header.
- mwr_data  out  32  payload beat.
- mwr_data_valid  out  1  payload beat valid.
- mwr_data_rdy  in  1  engine accepts the beat.
- half_irq  out  1  one-cycle pulse at the end of each half.
- half_idx  out  1  index of the half just completed; held until the next pulse.
- irq_ack  in  1  host acknowledge pulse.
- overrun_err  out  1  sticky overrun flag.
- burst_count  out  32  bursts completed since the last start; wraps at 2^32.

Behaviour:
- Reset: state IDLE. All outputs 0 (including half_idx, overrun_err, burst_count). Skid buffer empty, pending flag clear.
- FSM states: IDLE, WAIT_DATA, REQ, DATA, DONE.
- IDLE:
  - On a dma_enable rising edge: latch base and size; clear address offset, burst_count, overrun_err, pending, half_idx; go to WAIT_DATA.
  - A level-high dma_enable without an edge does not start the block.
- WAIT_DATA:
  - dma_enable low → IDLE.
  - Else if dma_ready → REQ on the next cycle.
- REQ:
  - mwr_req = 1; mwr_addr = base + offset; mwr_len = BURST_WORDS.
  - All three are held stable until mwr_ack. The cycle with mwr_ack drops mwr_req and enters DATA.
- DATA:
  - 2-entry skid buffer between the FIFO and the mwr_data path.
  - PCIe_dma_rd_en = 1 while words_read < BURST_WORDS and (occupancy + reads_in_flight) < 2. Rule: never more than 2 words outstanding.
  - mwr_data_valid = (occupancy > 0); mwr_data = skid head.
  - A beat transfers when valid & rdy.
  - Simultaneous fill and drain in one cycle leaves occupancy unchanged.
  - After exactly BURST_WORDS beats transferred → DONE. Total reads per burst is exactly BURST_WORDS.
- DONE (1 cycle):
  - burst_count += 1.
  - offset += BURST_WORDS*4.
  - If the within-buffer burst index reaches buf_half_bursts: half_irq = 1, half_idx = 0.
  - If it reaches 2*buf_half_bursts: half_irq = 1, half_idx = 1, offset wraps to 0.
  - Next state: WAIT_DATA.
- dma_enable falling mid-burst:
  - A burst in REQ or DATA always completes; a TLP is never truncated.
  - Return to IDLE via WAIT_DATA.
  - Offset is not reset until the next rising edge.
- Pending/overrun:
  - half_irq sets pending; irq_ack clears pending.
  - half_irq while pending is already set → overrun_err = 1 (sticky until the next start). Transfer continues regardless.
  - irq_ack in the same cycle as half_irq: ack is applied first, then pending is set again; no overrun.
  - irq_ack while not pending: ignored.
- mwr_addr arithmetic is modulo 2^ADDR_WIDTH; no carry check.
- Asynchronous reset mid-burst: everything returns immediately to reset values; any partial TLP is abandoned. The engine is reset by the same pio_reset_n.

Test Plan:
1. Basic burst: base=0x1000_0000, half=2, BURST_WORDS=32, FIFO preloaded with 0..255, dma_ready=1, mwr_ack one cycle after req, rdy=1 → four TLPs at 0x1000_0000/0080/0100/0180, each len=32 with data ascending. half_irq at bursts 2 (idx 0) and 4 (idx 1); burst_count=4; next address wraps to 0x1000_0000.
2. Backpressure: toggle mwr_data_rdy pseudo-randomly at 50% → payload order is preserved with no dropped or duplicated words. Never more than 2 reads outstanding. Exactly 32 PCIe_dma_rd_en pulses per burst.
3. Header hold: delay mwr_ack by 10 cycles → mwr_req, mwr_addr, mwr_len stay constant; no rd_en before ack.
4. Overrun: half=1, irq_ack withheld → second half_irq sets overrun_err=1. A later irq_ack does not clear it. The next dma_enable rising edge clears it. Same-cycle ack+irq → overrun_err stays 0.
5. Disable mid-burst: drop dma_enable at beat 5 → all 32 beats complete, FSM reaches IDLE, no further mwr_req even with dma_ready=1.
6. Reset mid-DATA: assert pio_reset_n=0 at beat 10 → all outputs 0 the same cycle. After release, no activity until a new dma_enable rising edge.

Source files
------------

// File: rtl/dma_burst_ctrl.sv
// Burst DMA controller: drains the ADC FIFO in fixed-size bursts and issues one
// PCIe memory-write TLP per burst while walking a two-half host ring buffer.
module dma_burst_ctrl #(
  parameter int BURST_WORDS = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  trn_clk,
  input  logic                  pio_reset_n,
  input  logic                  dma_enable,
  input  logic [ADDR_WIDTH-1:0] buf_base_addr,
  input  logic [15:0]           buf_half_bursts,
  input  logic                  dma_ready,
  output logic                  PCIe_dma_rd_en,
  input  logic [31:0]           fifo_data,
  output logic                  mwr_req,
  output logic [ADDR_WIDTH-1:0] mwr_addr,
  output logic [9:0]            mwr_len,
  input  logic                  mwr_ack,
  output logic [31:0]           mwr_data,
  output logic                  mwr_data_valid,
  input  logic                  mwr_data_rdy,
  output logic                  half_irq,
  output logic                  half_idx,
  input  logic                  irq_ack,
  output logic                  overrun_err,
  output logic [31:0]           burst_count
);

  localparam int CW = $clog2(BURST_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_DATA, S_REQ, S_DATA, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_en_d;
  logic [ADDR_WIDTH-1:0] r_base, r_offset;
  logic [15:0]           r_half;
  logic [16:0]           r_bidx;
  logic [CW-1:0]         r_words_read, r_beats;
  logic                  r_rd_inflight;
  logic [31:0]           r_skid0, r_skid1;
  logic [1:0]            r_occ;
  logic [31:0]           r_burst_count;
  logic                  r_half_idx, r_pending, r_overrun;

  logic        w_start, w_push, w_pop, w_last_beat;
  logic        w_half_hit, w_full_hit, w_irq;
  logic [16:0] w_bidx_next;
  logic [1:0]  w_outstanding;

  assign w_start     = dma_enable & ~r_en_d;
  assign w_push      = r_rd_inflight;
  assign w_pop       = mwr_data_valid & mwr_data_rdy;
  assign w_last_beat = w_pop && (r_beats == CW'(BURST_WORDS - 1));
  assign w_bidx_next = r_bidx + 17'd1;
  assign w_half_hit  = (r_state == S_DONE) && (w_bidx_next == {1'b0, r_half});
  assign w_full_hit  = (r_state == S_DONE) && (w_bidx_next == {r_half, 1'b0});
  assign w_irq       = w_half_hit | w_full_hit;
  assign w_outstanding = r_occ + {1'b0, r_rd_inflight};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  // NOTE: a default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_start) w_next = S_WAIT_DATA;
      S_WAIT_DATA: if (!dma_enable) w_next = S_IDLE;
                   else if (dma_ready) w_next = S_REQ;
      S_REQ:       if (mwr_ack) w_next = S_DATA;
      S_DATA:      if (w_last_beat) w_next = S_DONE;
      S_DONE:      w_next = S_WAIT_DATA;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mwr_req        = (r_state == S_REQ);
    mwr_addr       = mwr_req ? r_base + r_offset : '0;
    mwr_len        = mwr_req ? 10'(BURST_WORDS) : '0;
    PCIe_dma_rd_en = (r_state == S_DATA) && (r_words_read < CW'(BURST_WORDS)) &&
                     (w_outstanding < 2'd2);
    mwr_data_valid = (r_occ != 2'd0);
    mwr_data       = r_skid0;
    half_irq       = w_irq;
    half_idx       = w_irq ? w_full_hit : r_half_idx;
    overrun_err    = r_overrun;
    burst_count    = r_burst_count;
  end

  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      // Resets to 1 so an enable already high at reset release is not an edge.
      r_en_d        <= 1'b1;
      r_base        <= '0;
      r_offset      <= '0;
      r_half        <= 16'd1;
      r_bidx        <= '0;
      r_words_read  <= '0;
      r_beats       <= '0;
      r_rd_inflight <= 1'b0;
      r_skid0       <= '0;
      r_skid1       <= '0;
      r_occ         <= '0;
      r_burst_count <= '0;
      r_half_idx    <= 1'b0;
      r_pending     <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_en_d        <= dma_enable;
      r_rd_inflight <= PCIe_dma_rd_en;

      if (r_state == S_IDLE && w_start) begin
        r_base        <= buf_base_addr & ~ADDR_WIDTH'(3);
        r_half        <= (buf_half_bursts == 16'd0) ? 16'd1 : buf_half_bursts;
        r_offset      <= '0;
        r_bidx        <= '0;
        r_burst_count <= '0;
        r_overrun     <= 1'b0;
        r_pending     <= 1'b0;
        r_half_idx    <= 1'b0;
      end else if (w_irq) begin
        // A same-cycle ack clears the old request before the new one is posted.
        r_pending <= 1'b1;
        if (r_pending && !irq_ack) r_overrun <= 1'b1;
      end else if (irq_ack) begin
        r_pending <= 1'b0;
      end

      if (r_state == S_REQ && mwr_ack) begin
        r_words_read <= '0;
        r_beats      <= '0;
      end
      if (PCIe_dma_rd_en) r_words_read <= r_words_read + CW'(1);
      if (w_pop)          r_beats      <= r_beats + CW'(1);

      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_skid0 <= fifo_data;
          else               r_skid1 <= fifo_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_skid0 <= r_skid1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) r_skid0 <= fifo_data;
          else begin
            r_skid0 <= r_skid1;
            r_skid1 <= fifo_data;
          end
        end
        default: ;
      endcase

      if (r_state == S_DONE) begin
        r_burst_count <= r_burst_count + 32'd1;
        if (w_irq) r_half_idx <= w_full_hit;
        if (w_full_hit) begin
          r_offset <= '0;
          r_bidx   <= '0;
        end else begin
          r_offset <= r_offset + ADDR_WIDTH'(BURST_WORDS * 4);
          r_bidx   <= w_bidx_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed bench for dma_burst_ctrl: FIFO and TLP-engine models, stream
// monitor, and per-scenario checks against hand-computed values.
module tb_dma_burst_ctrl;

  localparam int BW = 32;
  localparam int AW = 32;

  logic          trn_clk = 1'b0;
  logic          pio_reset_n = 1'b0;
  logic          dma_enable = 1'b0;
  logic [AW-1:0] buf_base_addr = '0;
  logic [15:0]   buf_half_bursts = '0;
  logic          dma_ready = 1'b0;
  logic          PCIe_dma_rd_en;
  logic [31:0]   fifo_data = '0;
  logic          mwr_req;
  logic [AW-1:0] mwr_addr;
  logic [9:0]    mwr_len;
  logic          mwr_ack = 1'b0;
  logic [31:0]   mwr_data;
  logic          mwr_data_valid;
  logic          mwr_data_rdy = 1'b1;
  logic          half_irq;
  logic          half_idx;
  logic          irq_ack = 1'b0;
  logic          overrun_err;
  logic [31:0]   burst_count;

  dma_burst_ctrl #(.BURST_WORDS(BW), .ADDR_WIDTH(AW)) dut (
    .trn_clk(trn_clk), .pio_reset_n(pio_reset_n), .dma_enable(dma_enable),
    .buf_base_addr(buf_base_addr), .buf_half_bursts(buf_half_bursts),
    .dma_ready(dma_ready), .PCIe_dma_rd_en(PCIe_dma_rd_en), .fifo_data(fifo_data),
    .mwr_req(mwr_req), .mwr_addr(mwr_addr), .mwr_len(mwr_len), .mwr_ack(mwr_ack),
    .mwr_data(mwr_data), .mwr_data_valid(mwr_data_valid), .mwr_data_rdy(mwr_data_rdy),
    .half_irq(half_irq), .half_idx(half_idx), .irq_ack(irq_ack),
    .overrun_err(overrun_err), .burst_count(burst_count)
  );

  always #5 trn_clk = ~trn_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: word k holds A500_0000+k, delivered one cycle after rd_en.
  logic [31:0] rp = '0;
  always @(posedge trn_clk) begin
    if (PCIe_dma_rd_en) begin
      fifo_data <= 32'hA500_0000 + rp;
      rp        <= rp + 32'd1;
    end
  end

  // Scenario knobs, written only by the stimulus process.
  int   ack_delay = 1;
  bit   bp_mode = 0, auto_ack = 1, ack_sync = 0, man_ack = 0;
  int   clr_seq = 0;

  // Engine model and monitor state, written only by the negedge process.
  int            clr_seen = 0, req_wait = 0;
  bit            ack_pend = 0, req_prev = 0;
  int            req_cycles, req_count, hdr_changes, bad_len, rd_pulses, rd_before_ack;
  int            beats, bad_order, max_out, irq_cnt;
  logic [AW-1:0] hdr_addr;
  logic [9:0]    hdr_len;
  logic [31:0]   exp_word;
  logic [AW-1:0] addr_q[$];
  logic          idx_q[$];

  always @(negedge trn_clk) begin
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      req_cycles = 0; req_count = 0; hdr_changes = 0; bad_len = 0;
      rd_pulses = 0; rd_before_ack = 0; beats = 0; bad_order = 0;
      max_out = 0; irq_cnt = 0;
      addr_q.delete(); idx_q.delete();
      exp_word = 32'hA500_0000 + rp;
    end
    if (!pio_reset_n) begin
      mwr_ack = 1'b0; req_wait = 0; irq_ack = 1'b0; ack_pend = 0; req_prev = 0;
    end else begin
      if (mwr_req && !mwr_ack) begin
        if (req_wait == ack_delay) mwr_ack = 1'b1;
        else req_wait++;
      end else begin
        mwr_ack = 1'b0;
        req_wait = 0;
      end
      mwr_data_rdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      irq_ack  = ack_pend | man_ack | (ack_sync & half_irq);
      ack_pend = auto_ack & half_irq;

      if (mwr_req) begin
        req_cycles++;
        if (!req_prev) begin
          req_count++;
          hdr_addr = mwr_addr;
          hdr_len  = mwr_len;
        end else if (mwr_addr != hdr_addr || mwr_len != hdr_len) hdr_changes++;
      end
      if (mwr_req && mwr_ack) begin
        addr_q.push_back(mwr_addr);
        if (mwr_len != 10'd32) bad_len++;
      end
      if (PCIe_dma_rd_en) begin
        rd_pulses++;
        if (mwr_req) rd_before_ack++;
      end
      if (mwr_data_valid && mwr_data_rdy) begin
        beats++;
        if (mwr_data != exp_word) bad_order++;
        exp_word++;
      end
      if (rd_pulses - beats > max_out) max_out = rd_pulses - beats;
      if (half_irq) begin
        irq_cnt++;
        idx_q.push_back(half_idx);
      end
      req_prev = mwr_req;
    end
  end

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic clear_stats();
    clr_seq++;
    tick();
    tick();
  endtask

  task automatic start_dma(input logic [AW-1:0] base, input logic [15:0] half);
    dma_enable      = 1'b0;
    buf_base_addr   = base;
    buf_half_bursts = half;
    tick();
    dma_enable = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_ctrl", {mwr_req, PCIe_dma_rd_en, mwr_data_valid, half_irq, half_idx, overrun_err}, 0);
    check("rst_count", burst_count, 0);
    check("rst_hdr", {mwr_addr, mwr_len}, 0);
    check("rst_data", mwr_data, 0);
    pio_reset_n = 1'b1;
    dma_ready   = 1'b1;
    tick();

    // Basic bursts: half=2, four bursts walk the ring, fifth wraps to base.
    clear_stats();
    start_dma(32'h1000_0000, 16'd2);
    for (int i = 0; i < 3000 && addr_q.size() < 5; i++) tick();
    check("t1_hdr_wait", addr_q.size() >= 5, 1);
    dma_enable = 1'b0;
    for (int i = 0; i < 500 && burst_count != 5; i++) tick();
    check("t1_done_wait", burst_count, 5);
    repeat (20) tick();
    check("t1_addr0", addr_q[0], 32'h1000_0000);
    check("t1_addr1", addr_q[1], 32'h1000_0080);
    check("t1_addr2", addr_q[2], 32'h1000_0100);
    check("t1_addr3", addr_q[3], 32'h1000_0180);
    check("t1_addr4_wrap", addr_q[4], 32'h1000_0000);
    check("t1_irq_cnt", irq_cnt, 2);
    check("t1_irq_idx", {idx_q[0], idx_q[1]}, 2'b01);
    check("t1_idx_held", half_idx, 1);
    check("t1_beats", beats, 160);
    check("t1_reads", rd_pulses, 160);
    check("t1_order", bad_order, 0);
    check("t1_len", bad_len, 0);
    check("t1_overrun", overrun_err, 0);
    check("t1_req_cnt", req_count, 5);
    check("t1_count", burst_count, 5);

    // Backpressure: random rdy, order preserved, at most 2 outstanding.
    bp_mode = 1;
    clear_stats();
    start_dma(32'h2000_0000, 16'd4);
    for (int i = 0; i < 3000 && addr_q.size() < 3; i++) tick();
    check("t2_hdr_wait", addr_q.size() >= 3, 1);
    dma_enable = 1'b0;
    for (int i = 0; i < 1000 && burst_count != 3; i++) tick();
    check("t2_done_wait", burst_count, 3);
    repeat (20) tick();
    bp_mode = 0;
    check("t2_beats", beats, 96);
    check("t2_reads", rd_pulses, 96);
    check("t2_order", bad_order, 0);
    check("t2_max_out", max_out <= 2, 1);
    check("t2_addr2", addr_q[2], 32'h2000_0100);
    check("t2_irq_cnt", irq_cnt, 0);

    // Header hold under a 10-cycle ack delay; base low bits and half=0 -> 1.
    ack_delay = 10;
    clear_stats();
    start_dma(32'h3000_0007, 16'd0);
    for (int i = 0; i < 500 && addr_q.size() < 1; i++) tick();
    check("t3_hdr_wait", addr_q.size() >= 1, 1);
    dma_enable = 1'b0;
    for (int i = 0; i < 500 && burst_count != 1; i++) tick();
    repeat (20) tick();
    ack_delay = 1;
    check("t3_addr", addr_q[0], 32'h3000_0004);
    check("t3_req_cycles", req_cycles, 11);
    check("t3_hdr_stable", hdr_changes, 0);
    check("t3_rd_before_ack", rd_before_ack, 0);
    check("t3_irq_cnt", irq_cnt, 1);
    check("t3_irq_idx", idx_q[0], 0);
    check("t3_beats", beats, 32);

    // Overrun: half=1 with acks withheld.
    auto_ack = 0;
    clear_stats();
    start_dma(32'h4000_0000, 16'd1);
    for (int i = 0; i < 1000 && addr_q.size() < 2; i++) tick();
    dma_enable = 1'b0;
    for (int i = 0; i < 500 && burst_count != 2; i++) tick();
    repeat (10) tick();
    check("t4_irq_cnt", irq_cnt, 2);
    check("t4_irq_idx", {idx_q[0], idx_q[1]}, 2'b01);
    check("t4_overrun_set", overrun_err, 1);
    man_ack = 1;
    tick();
    man_ack = 0;
    repeat (3) tick();
    check("t4_overrun_sticky", overrun_err, 1);

    // Restart clears the flag; ack coinciding with every irq never overruns.
    ack_sync = 1;
    clear_stats();
    start_dma(32'h4000_0000, 16'd1);
    check("t4_overrun_clr", overrun_err, 0);
    for (int i = 0; i < 2000 && addr_q.size() < 3; i++) tick();
    dma_enable = 1'b0;
    for (int i = 0; i < 500 && burst_count != 3; i++) tick();
    repeat (10) tick();
    ack_sync = 0;
    auto_ack = 1;
    check("t4_sync_irq_cnt", irq_cnt, 3);
    check("t4_sync_overrun", overrun_err, 0);

    // Disable at beat 5: burst still completes, then the block stays idle.
    clear_stats();
    start_dma(32'h5000_0000, 16'd8);
    for (int i = 0; i < 500 && beats < 5; i++) tick();
    check("t5_beat_wait", beats >= 5, 1);
    dma_enable = 1'b0;
    for (int i = 0; i < 500 && burst_count != 1; i++) tick();
    repeat (100) tick();
    check("t5_beats", beats, 32);
    check("t5_reads", rd_pulses, 32);
    check("t5_order", bad_order, 0);
    check("t5_req_cnt", req_count, 1);
    check("t5_count", burst_count, 1);

    // Reset at beat 10 of the second burst.
    clear_stats();
    start_dma(32'h6000_0000, 16'd2);
    for (int i = 0; i < 1000 && beats < 42; i++) tick();
    check("t6_beat_wait", beats >= 42, 1);
    check("t6_pre_count", burst_count, 1);
    pio_reset_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {mwr_req, PCIe_dma_rd_en, mwr_data_valid, half_irq, half_idx, overrun_err}, 0);
    check("t6_rst_count", burst_count, 0);
    check("t6_rst_hdr", {mwr_addr, mwr_len}, 0);
    check("t6_rst_data", mwr_data, 0);
    repeat (3) tick();
    pio_reset_n = 1'b1;
    clear_stats();
    repeat (50) tick();
    check("t6_no_req", req_count, 0);
    check("t6_no_rd", rd_pulses, 0);
    start_dma(32'h6000_0000, 16'd2);
    for (int i = 0; i < 500 && addr_q.size() < 1; i++) tick();
    dma_enable = 1'b0;
    for (int i = 0; i < 500 && burst_count != 1; i++) tick();
    repeat (20) tick();
    check("t6_restart_addr", addr_q[0], 32'h6000_0000);
    check("t6_restart_beats", beats, 32);
    check("t6_restart_order", bad_order, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
